usb_rx_fifo: RTL and testbench

USB_RX_FIFO -- requirements
Module: usb_rx_fifo

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/usb_rx_fifo_sync_2ff.sv | 22 ++
 rtl/usb_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_usb_rx_fifo.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive FIFO.
// Status bit positions, read FSM states and default depth.
package usb_rx_pkg;

  localparam int DEPTH_DEF = 16;

  localparam int ST_RXA  = 0;
  localparam int ST_TXE  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FULL = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_RD = 2'd1,
    STAT_RD = 2'd2
  } rd_state_e;

endpackage

// File: rtl/usb_rx_fifo_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Used to bring the Z80 read strobe into the 250 MHz domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_rx_fifo.sv
// USB receive FIFO with Z80 data/status read ports.
// Overrun tracking is compiled in only with USB_RX_OVERRUN_EN.
module usb_rx_fifo
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       pll0_250MHz,
  input  logic       n_reset,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  input  logic       cpuRd,
  input  logic       usbRxD_cs,
  input  logic       usbStat_cs,
  input  logic       usbTxEmpty,
  output logic [7:0] usbRxD,
  output logic [7:0] usbStatus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  logic      rd_sync;
  logic      rd_data;
  logic      rd_stat;
  rd_state_e state;
  rd_state_e state_nxt;
  logic      pop_req;
  logic      stat_clr;

  logic do_push;
  logic do_pop;
  logic rxa_q;
  logic full_q;
  logic ovr;

  sync_2ff u_sync (
    .clk   (pll0_250MHz),
    .rst_n (n_reset),
    .d     (cpuRd),
    .q     (rd_sync)
  );

  assign rd_data = rd_sync & usbRxD_cs;
  assign rd_stat = rd_sync & usbStat_cs;

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // Pops fire on the falling edge of the read so the byte holds all read long.
  always_comb begin
    state_nxt = state;
    pop_req   = 1'b0;
    stat_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_data)      state_nxt = DATA_RD;
        else if (rd_stat) state_nxt = STAT_RD;
      end
      DATA_RD: begin
        if (!rd_data) begin
          state_nxt = IDLE;
          pop_req   = 1'b1;
        end
      end
      STAT_RD: begin
        if (!rd_stat) begin
          state_nxt = IDLE;
          stat_clr  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign do_pop  = pop_req & (count != '0);
  assign do_push = rxValid & ((count != CNT_FULL) | do_pop);

  always_comb begin
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rxa_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      rxa_q  <= (count_nxt != '0);
      full_q <= (count_nxt == CNT_FULL);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge pll0_250MHz) begin
    if (do_push) mem[wr_ptr] <= rxData;
  end

`ifdef USB_RX_OVERRUN_EN
  logic drop;

  assign drop = rxValid & ~do_push;

  // A drop wins over a clear landing in the same cycle.
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset)      ovr <= 1'b0;
    else if (drop)     ovr <= 1'b1;
    else if (stat_clr) ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
`endif

  assign usbRxD = (count != '0) ? mem[rd_ptr] : 8'h00;

  always_comb begin
    usbStatus          = '0;
    usbStatus[ST_RXA]  = rxa_q;
    usbStatus[ST_TXE]  = usbTxEmpty;
    usbStatus[ST_OVR]  = ovr;
    usbStatus[ST_FULL] = full_q;
  end

endmodule

// File: tb/tb_usb_rx_fifo.sv
// Randomized self-checking bench for usb_rx_fifo.
// Expected values come from a queue-based model of the FIFO.
module tb_usb_rx_fifo;
  import usb_rx_pkg::*;

  localparam int DEPTH = 16;

  logic       clk;
  logic       n_reset;
  logic [7:0] rxData;
  logic       rxValid;
  logic       cpuRd;
  logic       usbRxD_cs;
  logic       usbStat_cs;
  logic       usbTxEmpty;
  logic [7:0] usbRxD;
  logic [7:0] usbStatus;

  int tests = 0;
  int fails = 0;

  logic [7:0] q [$];
  bit         ovr_m;

  usb_rx_fifo #(.DEPTH(DEPTH)) dut (
    .pll0_250MHz (clk),
    .n_reset     (n_reset),
    .rxData      (rxData),
    .rxValid     (rxValid),
    .cpuRd       (cpuRd),
    .usbRxD_cs   (usbRxD_cs),
    .usbStat_cs  (usbStat_cs),
    .usbTxEmpty  (usbTxEmpty),
    .usbRxD      (usbRxD),
    .usbStatus   (usbStatus)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (q.size() != 0);
    s[1] = usbTxEmpty;
`ifdef USB_RX_OVERRUN_EN
    s[2] = ovr_m;
`endif
    s[3] = (q.size() == DEPTH);
    return s;
  endfunction

  function automatic logic [7:0] exp_data();
    return (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid = 1'b0;
    if (q.size() < DEPTH) q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic cpu_read(input bit is_stat, input int hold,
                          output bit stable, output logic [7:0] seen);
    usbRxD_cs  = !is_stat;
    usbStat_cs = is_stat;
    cpuRd      = 1'b1;
    seen       = usbRxD;
    stable     = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (usbRxD !== seen) stable = 1'b0;
    end
    cpuRd = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    usbRxD_cs  = 1'b0;
    usbStat_cs = 1'b0;
    if (is_stat) ovr_m = 1'b0;
    else if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic test_reset();
    n_reset    = 1'b0;
    rxData     = 8'h00;
    rxValid    = 1'b0;
    cpuRd      = 1'b0;
    usbRxD_cs  = 1'b0;
    usbStat_cs = 1'b0;
    usbTxEmpty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (usbRxD !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got %h want 00", usbRxD);
    end
    tests++;
    if (usbStatus !== 8'h02) begin
      fails++;
      $display("FAIL reset_status_txe1 got %h want 02", usbStatus);
    end
    usbTxEmpty = 1'b0;
    #1;
    tests++;
    if (usbStatus !== 8'h00) begin
      fails++;
      $display("FAIL reset_status_txe0 got %h want 00", usbStatus);
    end
    @(posedge clk); #1;
    n_reset    = 1'b1;
    usbTxEmpty = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit         st;
    logic [7:0] seen;
    push_byte(8'h41);
    push_byte(8'h42);
    tests++;
    if (usbRxD !== 8'h41) begin
      fails++;
      $display("FAIL basic_head got %h want 41", usbRxD);
    end
    tests++;
    if (usbStatus !== exp_status()) begin
      fails++;
      $display("FAIL basic_status got %h want %h", usbStatus, exp_status());
    end
    cpu_read(1'b0, 20, st, seen);
    tests++;
    if (!st || seen !== 8'h41) begin
      fails++;
      $display("FAIL basic_hold stable=%0d got %h want 41", st, seen);
    end
    tests++;
    if (usbRxD !== 8'h42) begin
      fails++;
      $display("FAIL basic_single_pop got %h want 42", usbRxD);
    end
    cpu_read(1'b0, 20, st, seen);
    tests++;
    if (usbRxD !== 8'h00 || usbStatus !== exp_status()) begin
      fails++;
      $display("FAIL basic_drain got %h/%h want 00/%h",
               usbRxD, usbStatus, exp_status());
    end
  endtask

  task automatic test_full_overrun();
    bit         st;
    logic [7:0] seen;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    tests++;
    if (usbStatus !== 8'h0b) begin
      fails++;
      $display("FAIL full_status got %h want 0b", usbStatus);
    end
    push_byte(8'hee);
    tests++;
    if (usbStatus !== exp_status()) begin
      fails++;
      $display("FAIL overrun_status got %h want %h", usbStatus, exp_status());
    end
    tests++;
    if (usbRxD !== 8'h10) begin
      fails++;
      $display("FAIL overrun_head got %h want 10", usbRxD);
    end
    cpu_read(1'b1, 12, st, seen);
    tests++;
    if (usbStatus !== exp_status() || usbRxD !== 8'h10) begin
      fails++;
      $display("FAIL stat_clear got %h/%h want %h/10",
               usbStatus, usbRxD, exp_status());
    end
  endtask

  task automatic test_full_push_pop();
    bit         hit;
    bit         st;
    logic [7:0] seen;
    logic [7:0] last;
    usbRxD_cs = 1'b1;
    cpuRd     = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    cpuRd = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (dut.pop_req === 1'b1) hit = 1'b1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL pushpop_window got no pop want pop");
    end
    rxData  = 8'h5a;
    rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid   = 1'b0;
    usbRxD_cs = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h5a);
    tests++;
    if (usbStatus !== exp_status() || usbStatus[2] !== 1'b0) begin
      fails++;
      $display("FAIL pushpop_status got %h want %h", usbStatus, exp_status());
    end
    tests++;
    if (dut.count !== 5'(DEPTH)) begin
      fails++;
      $display("FAIL pushpop_count got %0d want %0d", dut.count, DEPTH);
    end
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (usbRxD !== exp_data()) begin
        fails++;
        $display("FAIL drain_%0d got %h want %h", i, usbRxD, exp_data());
      end
      last = usbRxD;
      cpu_read(1'b0, 4, st, seen);
    end
    tests++;
    if (last !== 8'h5a || usbStatus !== exp_status()) begin
      fails++;
      $display("FAIL pushpop_last got %h/%h want 5a/%h",
               last, usbStatus, exp_status());
    end
  endtask

  task automatic test_empty_read();
    bit         st;
    logic [7:0] seen;
    cpu_read(1'b0, 8, st, seen);
    tests++;
    if (usbRxD !== 8'h00 || usbStatus[0] !== 1'b0 || dut.count !== 5'd0) begin
      fails++;
      $display("FAIL empty_read got %h/%h want 00/%h",
               usbRxD, usbStatus, exp_status());
    end
    push_byte(8'h77);
    tests++;
    if (usbRxD !== 8'h77 || usbStatus !== exp_status()) begin
      fails++;
      $display("FAIL empty_then_push got %h/%h want 77/%h",
               usbRxD, usbStatus, exp_status());
    end
    cpu_read(1'b0, 4, st, seen);
  endtask

  task automatic test_wrap();
    bit         st;
    logic [7:0] seen;
    logic [7:0] want;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      push_byte(8'($urandom));
      usbTxEmpty = 1'($urandom);
      want = exp_data();
      cpu_read(1'b0, 3, st, seen);
      tests++;
      if (!st || seen !== want || usbRxD !== exp_data()
          || usbStatus !== exp_status()) begin
        fails++;
        $display("FAIL wrap_%0d got %h/%h/%h want %h/%h/%h", i,
                 seen, usbRxD, usbStatus, want, exp_data(), exp_status());
      end
    end
  endtask

  task automatic test_random();
    bit         st;
    logic [7:0] seen;
    logic [7:0] want;
    int         r;
    for (int i = 0; i < 120; i++) begin
      r    = int'($urandom_range(0, 9));
      want = exp_data();
      st   = 1'b1;
      seen = want;
      if (r < 6) begin
        push_byte(8'($urandom));
      end else if (r < 9) begin
        cpu_read(1'b0, 2, st, seen);
      end else begin
        usbTxEmpty = 1'($urandom);
        cpu_read(1'b1, 2, st, seen);
      end
      tests++;
      if (!st || seen !== want || usbRxD !== exp_data()
          || usbStatus !== exp_status()) begin
        fails++;
        $display("FAIL rand_%0d got %h/%h/%h want %h/%h/%h", i,
                 seen, usbRxD, usbStatus, want, exp_data(), exp_status());
      end
    end
  endtask

  task automatic test_reset_mid_read();
    while (q.size() != 0) begin
      bit         st;
      logic [7:0] seen;
      cpu_read(1'b0, 2, st, seen);
    end
    push_byte(8'ha1);
    push_byte(8'ha2);
    push_byte(8'ha3);
    usbTxEmpty = 1'b1;
    usbRxD_cs  = 1'b1;
    cpuRd      = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    n_reset = 1'b0;
    #1;
    q.delete();
    ovr_m = 1'b0;
    tests++;
    if (usbRxD !== 8'h00 || usbStatus !== 8'h02 || dut.state !== IDLE) begin
      fails++;
      $display("FAIL rst_mid got %h/%h/%0d want 00/02/IDLE",
               usbRxD, usbStatus, dut.state);
    end
    cpuRd     = 1'b0;
    usbRxD_cs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_reset = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    tests++;
    if (usbRxD !== 8'h00 || usbStatus !== 8'h02 || dut.count !== 5'd0) begin
      fails++;
      $display("FAIL rst_after got %h/%h want 00/02", usbRxD, usbStatus);
    end
    push_byte(8'hc4);
    tests++;
    if (usbRxD !== 8'hc4 || usbStatus !== exp_status()) begin
      fails++;
      $display("FAIL rst_push got %h/%h want c4/%h",
               usbRxD, usbStatus, exp_status());
    end
  endtask

  initial begin
    ovr_m = 1'b0;
    test_reset();
    test_basic();
    test_full_overrun();
    test_full_push_pop();
    test_empty_read();
    test_wrap();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
